// File: rtl/game_pkg.sv
// Shared types and constants for the reaction-timer game sequencer.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    GO    = 3'd2,
    DONE  = 3'd3,
    FOUL  = 3'd4
  } state_t;

  localparam logic [3:0]  BLANK_DIGIT       = 4'hF;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronizes a raw asynchronous button and emits a one-cycle pulse on each press.
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level;
  logic                   level_d;

  // level/level_d form the edge detector behind the synchronizer chain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], btn};
      level   <= sync[SYNC_STAGES-1];
      level_d <= level;
      pulse   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/reaction_game_ctrl.sv
// Round sequencer for the reaction timer: random arm delay, GO, BCD tenths count, result hold.
module reaction_game_ctrl
  import game_pkg::*;
#(
  parameter int          DELAY_MIN_TICKS = 10,
  parameter int          DELAY_BITS      = 5,
  parameter int          SYNC_STAGES     = 2,
  parameter logic [15:0] LFSR_SEED       = DEFAULT_LFSR_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_btn,
  input  logic       stop_btn,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       go_led,
  output logic       foul,
  output logic       overflow,
  output logic       busy
);

  localparam int DCNT_W = $clog2(DELAY_MIN_TICKS + (1 << DELAY_BITS));

  state_t            state;
  logic [15:0]       lfsr;
  logic [DCNT_W-1:0] delay_cnt;
  logic [DCNT_W-1:0] delay_load;
  logic              start_p;
  logic              stop_p;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (
    .clk   (clk),
    .reset (reset),
    .btn   (start_btn),
    .pulse (start_p)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stop (
    .clk   (clk),
    .reset (reset),
    .btn   (stop_btn),
    .pulse (stop_p)
  );

  assign delay_load = DCNT_W'(DELAY_MIN_TICKS) + DCNT_W'(lfsr[DELAY_BITS-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  // tens/ones double as the live BCD counter while in GO and DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      delay_cnt <= '0;
      tens      <= BLANK_DIGIT;
      ones      <= BLANK_DIGIT;
      go_led    <= 1'b0;
      foul      <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, FOUL: begin
          if (start_p) begin
            state     <= ARMED;
            delay_cnt <= delay_load;
            tens      <= BLANK_DIGIT;
            ones      <= BLANK_DIGIT;
            go_led    <= 1'b0;
            foul      <= 1'b0;
            overflow  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ARMED: begin
          if (stop_p) begin
            state <= FOUL;
            foul  <= 1'b1;
            busy  <= 1'b0;
          end else if (tick) begin
            if (delay_cnt == DCNT_W'(1)) begin
              state  <= GO;
              go_led <= 1'b1;
              tens   <= 4'd0;
              ones   <= 4'd0;
            end else begin
              delay_cnt <= delay_cnt - DCNT_W'(1);
            end
          end
        end
        GO: begin
          // A stop in the same cycle as a tick freezes the count before that tick
          if (stop_p) begin
            state  <= DONE;
            go_led <= 1'b0;
            busy   <= 1'b0;
          end else if (tick) begin
            if (tens == 4'd9 && ones == 4'd9) begin
              state    <= DONE;
              overflow <= 1'b1;
              go_led   <= 1'b0;
              busy     <= 1'b0;
            end else if (ones == 4'd9) begin
              ones <= 4'd0;
              tens <= tens + 4'd1;
            end else begin
              ones <= ones + 4'd1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          tens     <= BLANK_DIGIT;
          ones     <= BLANK_DIGIT;
          go_led   <= 1'b0;
          foul     <= 1'b0;
          overflow <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed self-checking bench for reaction_game_ctrl.
module tb_reaction_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       go_led;
  logic       foul;
  logic       overflow;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int exp_delay;
  int got_delay;

  logic [15:0] m_lfsr;

  reaction_game_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start_btn (start_btn),
    .stop_btn  (stop_btn),
    .tens      (tens),
    .ones      (ones),
    .go_led    (go_led),
    .foul      (foul),
    .overflow  (overflow),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference LFSR: seed 16'hACE1, x^16+x^14+x^13+x^11+1, one step per clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick_one();
    repeat (19) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_one();
  endtask

  // Button raised at a negedge reaches the FSM on the 5th rising edge after it
  task automatic press_start(input int hold);
    start_btn = 1'b1;
    repeat (4) @(negedge clk);
    exp_delay = 10 + int'(m_lfsr[4:0]);
    repeat (hold - 4) @(negedge clk);
    start_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic press_stop(input int hold);
    stop_btn = 1'b1;
    repeat (hold) @(negedge clk);
    stop_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic stop_with_tick();
    stop_btn = 1'b1;
    repeat (4) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    stop_btn = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_go(input string tag);
    got_delay = 0;
    while (!go_led && got_delay < 60) begin
      tick_one();
      got_delay++;
    end
    check(tag, got_delay, exp_delay);
  endtask

  initial begin
    // 1: reset state, arm, random delay
    repeat (3) @(negedge clk);
    check("rst_tens", tens, 15);
    check("rst_ones", ones, 15);
    check("rst_flags", {go_led, foul, overflow, busy}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    press_start(6);
    check("arm_busy", busy, 1);
    check("arm_go", go_led, 0);
    check("arm_tens", tens, 15);
    wait_go("delay1");
    check("delay_range", int'(got_delay >= 10 && got_delay <= 41), 1);
    check("go_start", {tens, ones}, 8'h00);

    // 2: stop after 5 ticks, held long
    ticks(5);
    check("go_05", {tens, ones}, 8'h05);
    repeat (5) @(negedge clk);
    press_stop(200);
    check("done_val", {tens, ones}, 8'h05);
    check("done_flags", {go_led, foul, overflow, busy}, 0);
    ticks(2);
    check("done_hold", {tens, ones}, 8'h05);

    // 3: early press gives FOUL
    press_start(6);
    ticks(3);
    press_stop(6);
    check("foul_flag", foul, 1);
    check("foul_digits", {tens, ones}, 8'hFF);
    check("foul_busy", busy, 0);
    ticks(45);
    check("foul_no_go", {go_led, foul}, 1);
    press_start(6);
    check("rearm_flags", {foul, busy}, 1);

    // 4: full count to overflow
    wait_go("delay2");
    for (int e = 1; e <= 99; e++) begin
      tick_one();
      check("bcd_walk", {tens, ones}, ((e / 10) << 4) | (e % 10));
    end
    tick_one();
    check("ovf_val", {tens, ones}, 8'h99);
    check("ovf_flags", {go_led, foul, overflow, busy}, 4'b0010);
    press_start(6);
    check("ovf_clear", {overflow, busy}, 1);

    // 5: stop coinciding with a tick
    wait_go("delay3");
    ticks(37);
    check("go_37", {tens, ones}, 8'h37);
    stop_with_tick();
    check("stop_wins", {tens, ones}, 8'h37);
    check("stop_go", go_led, 0);
    press_start(6);
    ticks(exp_delay - 1);
    check("last_armed", {go_led, busy}, 1);
    stop_with_tick();
    check("late_foul", {go_led, foul}, 1);
    check("late_foul_dig", {tens, ones}, 8'hFF);

    // 6: asynchronous reset mid-count
    press_start(6);
    wait_go("delay4");
    ticks(42);
    check("go_42", {tens, ones}, 8'h42);
    #1 reset = 1'b1;
    #1;
    check("async_digits", {tens, ones}, 8'hFF);
    check("async_flags", {go_led, foul, overflow, busy}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    press_stop(6);
    check("idle_stop", {tens, ones, go_led, foul, overflow, busy}, 12'hFF0);
    press_start(6);
    check("post_rst_busy", busy, 1);
    wait_go("delay5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
